// File: rtl/button_toggle_conditioner.sv
// Pushbutton conditioner: two-flop sync, stable-count debounce,
// one-cycle press/release pulses and a wrapping press counter.
module button_toggle_conditioner #(
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = 5,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  output logic       t_pulse,
  output logic       rel_pulse,
  output logic       level,
  output logic [7:0] press_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PRESS,
    HELD,
    WAIT_RELEASE
  } state_t;

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic             LP_REL  = ACTIVE_LOW;

  logic             r_s1;
  logic             r_s2;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_tp;
  logic             r_rp;
  logic             r_lvl;
  logic [7:0]       r_pc;

  state_t           w_state_nx;
  logic [CNT_W-1:0] w_cnt_nx;
  logic             w_tp_nx;
  logic             w_rp_nx;
  logic             w_lvl_nx;
  logic [7:0]       w_pc_nx;
  logic             w_p;
  logic             w_last;

  // 1 = pressed, independent of board polarity
  assign w_p    = r_s2 ^ LP_REL;
  assign w_last = (r_cnt == LP_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1    <= LP_REL;
      r_s2    <= LP_REL;
      r_state <= IDLE;
      r_cnt   <= '0;
      r_tp    <= 1'b0;
      r_rp    <= 1'b0;
      r_lvl   <= 1'b0;
      r_pc    <= '0;
    end else begin
      r_s1    <= btn;
      r_s2    <= r_s1;
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_tp    <= w_tp_nx;
      r_rp    <= w_rp_nx;
      r_lvl   <= w_lvl_nx;
      r_pc    <= w_pc_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_tp_nx    = 1'b0;
    w_rp_nx    = 1'b0;
    w_lvl_nx   = r_lvl;
    w_pc_nx    = r_pc;
    case (r_state)
      IDLE: begin
        if (w_p) begin
          w_state_nx = WAIT_PRESS;
          w_cnt_nx   = CNT_W'(1);
        end else begin
          w_cnt_nx   = '0;
        end
      end
      WAIT_PRESS: begin
        if (!w_p) begin
          w_state_nx = IDLE;
          w_cnt_nx   = '0;
        end else if (w_last) begin
          w_state_nx = HELD;
          w_cnt_nx   = '0;
          w_tp_nx    = 1'b1;
          w_lvl_nx   = 1'b1;
          w_pc_nx    = r_pc + 8'd1;
        end else begin
          w_cnt_nx   = r_cnt + CNT_W'(1);
        end
      end
      HELD: begin
        if (!w_p) begin
          w_state_nx = WAIT_RELEASE;
          w_cnt_nx   = CNT_W'(1);
        end
      end
      WAIT_RELEASE: begin
        if (w_p) begin
          w_state_nx = HELD;
          w_cnt_nx   = '0;
        end else if (w_last) begin
          w_state_nx = IDLE;
          w_cnt_nx   = '0;
          w_rp_nx    = 1'b1;
          w_lvl_nx   = 1'b0;
        end else begin
          w_cnt_nx   = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_cnt_nx   = '0;
      end
    endcase
  end

  assign t_pulse   = r_tp;
  assign rel_pulse = r_rp;
  assign level     = r_lvl;
  assign press_cnt = r_pc;

endmodule

// File: tb/tb_button_toggle_conditioner.sv
// Bench for button_toggle_conditioner: run-length reference model
// feeding a scoreboard, plus directed latency and reset checks.
module tb_button_toggle_conditioner;

  localparam int S  = 16;
  localparam bit AL = 1'b1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn = AL;
  logic       t_pulse;
  logic       rel_pulse;
  logic       level;
  logic [7:0] press_cnt;

  int checks = 0;
  int errors = 0;
  int tcount = 0;
  int rcount = 0;
  bit tff    = 1'b0;

  typedef struct packed {
    logic       tp;
    logic       rp;
    logic       lv;
    logic [7:0] pc;
  } exp_t;

  exp_t q[$];

  button_toggle_conditioner #(
    .STABLE_CYCLES(S),
    .CNT_W(5),
    .ACTIVE_LOW(AL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn(btn),
    .t_pulse(t_pulse),
    .rel_pulse(rel_pulse),
    .level(level),
    .press_cnt(press_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d @%0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference: btn reaches the decision two edges late; the debounced
  // level flips once S consecutive samples disagree with it.
  initial begin : model
    bit   b1, b2, p, mlv;
    int   run;
    int   mpc;
    exp_t e;
    b1 = AL; b2 = AL; mlv = 0; run = 0; mpc = 0;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        b1 = AL; b2 = AL; mlv = 0; run = 0; mpc = 0;
        q.delete();
      end else begin
        p  = b2 ^ AL;
        b2 = b1;
        b1 = btn;
        e  = '0;
        if (p != mlv) begin
          run++;
          if (run == S) begin
            mlv = p;
            run = 0;
            if (p) begin
              e.tp = 1'b1;
              mpc  = (mpc + 1) % 256;
            end else begin
              e.rp = 1'b1;
            end
          end
        end else begin
          run = 0;
        end
        e.lv = mlv;
        e.pc = 8'(mpc);
        q.push_back(e);
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (t_pulse === 1'b1) begin
        tcount++;
        tff = ~tff;
      end
      if (rel_pulse === 1'b1) rcount++;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("scoreboard {tp,rp,lv,pc}",
            int'({t_pulse, rel_pulse, level, press_cnt}), int'(e));
      end
    end
  end

  initial begin : stim
    int  t0, r0, pc0;
    bit  tff0;
    rst = 1'b0;
    btn = AL;
    #12;
    chk("reset t_pulse", int'(t_pulse), 0);
    chk("reset rel_pulse", int'(rel_pulse), 0);
    chk("reset level", int'(level), 0);
    chk("reset press_cnt", int'(press_cnt), 0);
    @(negedge clk);
    rst = 1'b1;
    cyc(50);
    chk("idle no t_pulse", tcount, 0);
    chk("idle no rel_pulse", rcount, 0);

    // clean press, exact latency
    btn = ~AL;
    cyc(17);
    chk("press edge17 t_pulse", int'(t_pulse), 0);
    cyc(1);
    chk("press edge18 t_pulse", int'(t_pulse), 1);
    chk("press edge18 level", int'(level), 1);
    cyc(1);
    chk("press edge19 t_pulse", int'(t_pulse), 0);
    chk("press press_cnt", int'(press_cnt), 1);
    cyc(10);
    btn = AL;
    cyc(17);
    chk("release edge17 rel", int'(rel_pulse), 0);
    cyc(1);
    chk("release edge18 rel", int'(rel_pulse), 1);
    chk("release level", int'(level), 0);
    cyc(1);
    chk("release edge19 rel", int'(rel_pulse), 0);
    cyc(20);

    // bouncing press
    t0 = tcount;
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) btn = ~btn;
      cyc(1);
    end
    btn = ~AL;
    cyc(17);
    chk("bounce no early pulse", tcount - t0, 0);
    cyc(1);
    chk("bounce edge18 t_pulse", int'(t_pulse), 1);
    cyc(10);
    chk("bounce single pulse", tcount - t0, 1);
    chk("bounce press_cnt", int'(press_cnt), 2);
    btn = AL;
    cyc(40);

    // 15-cycle low glitch
    t0 = tcount;
    btn = ~AL;
    cyc(S - 1);
    btn = AL;
    cyc(40);
    chk("short glitch no pulse", tcount - t0, 0);

    // release glitch while held
    btn = ~AL;
    cyc(40);
    r0 = rcount;
    btn = AL;
    cyc(10);
    btn = ~AL;
    cyc(40);
    chk("rel glitch no rel_pulse", rcount - r0, 0);
    chk("rel glitch level", int'(level), 1);
    btn = AL;
    cyc(40);

    // random segments against the model
    for (int k = 0; k < 40; k++) begin
      btn = 1'($urandom_range(1, 0));
      cyc($urandom_range(40, 1));
    end
    btn = AL;
    cyc(40);

    // 256 presses wrap the counter
    t0   = tcount;
    pc0  = int'(press_cnt);
    tff0 = tff;
    for (int k = 0; k < 256; k++) begin
      btn = ~AL;
      cyc(2 * S + 4);
      btn = AL;
      cyc(2 * S + 4);
    end
    chk("wrap pulse count", tcount - t0, 256);
    chk("wrap press_cnt", int'(press_cnt), pc0);
    chk("wrap tff restored", int'(tff), int'(tff0));

    // reset in WAIT_PRESS with cnt=10
    btn = ~AL;
    cyc(12);
    #1 rst = 1'b0;
    #1;
    chk("midcount rst t_pulse", int'(t_pulse), 0);
    chk("midcount rst level", int'(level), 0);
    chk("midcount rst press_cnt", int'(press_cnt), 0);
    @(negedge clk);
    rst = 1'b1;
    t0 = tcount;
    cyc(17);
    chk("after rst edge17", int'(t_pulse), 0);
    cyc(1);
    chk("after rst edge18", int'(t_pulse), 1);

    // reset during the pulse
    #1 rst = 1'b0;
    #1;
    chk("pulse rst t_pulse", int'(t_pulse), 0);
    chk("pulse rst level", int'(level), 0);
    chk("pulse rst press_cnt", int'(press_cnt), 0);
    @(negedge clk);
    rst = 1'b1;
    cyc(18);
    chk("after rst2 edge18", int'(t_pulse), 1);
    cyc(10);
    chk("after rst2 pulses", tcount - t0, 2);
    chk("after rst2 press_cnt", int'(press_cnt), 1);
    btn = AL;
    cyc(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
